// File: rtl/lab3_pkg.sv
// rtl/lab3_pkg.sv - shared constants and FSM encoding for the lab3 BCD blocks
package lab3_pkg;

   localparam int DIGIT_W  = 4;
   localparam int BCD_MAX  = 9;
   localparam int BCD_CORR = 6;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADD  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = S_IDLE,
      ST_ADD  = S_ADD,
      ST_DONE = S_DONE
   } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - combinational single-digit BCD adder with +6 correction
// Non-BCD inputs go through the same rule; no saturation.
module bcd_digit_add
   import lab3_pkg::*;
(
   input  logic [DIGIT_W-1:0] da,
   input  logic [DIGIT_W-1:0] db,
   input  logic               ci,
   output logic [DIGIT_W-1:0] d,
   output logic               co
);

   localparam int SW = DIGIT_W + 1;

   logic [SW-1:0] s;
   logic [SW-1:0] s_corr;

   always_comb begin
      s      = {1'b0, da} + {1'b0, db} + {{DIGIT_W{1'b0}}, ci};
      s_corr = s + SW'(BCD_CORR);
      d      = s[DIGIT_W-1:0];
      co     = 1'b0;
      if (s > SW'(BCD_MAX)) begin
         d  = s_corr[DIGIT_W-1:0];
         co = 1'b1;
      end
   end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// rtl/bcd_serial_add_ctrl.sv - digit-serial NDIG-digit BCD adder sequencer
// One digit per clock, LSD first; carry rippled through a register; registered busy/done.
module bcd_serial_add_ctrl
   import lab3_pkg::*;
#(
   parameter int NDIG = 3
) (
   input  logic                    CLOCK_50,
   input  logic                    Resetn,
   input  logic                    start,
   input  logic [DIGIT_W*NDIG-1:0] a,
   input  logic [DIGIT_W*NDIG-1:0] b,
   input  logic                    cin,
   output logic                    busy,
   output logic                    done,
   output logic [DIGIT_W*NDIG-1:0] sum,
   output logic                    cout,
   output logic                    err
);

   localparam int W     = DIGIT_W * NDIG;
   localparam int CNT_W = $clog2(NDIG) + 1;

   state_t             state, state_nxt;
   logic [W-1:0]       op_a, op_b, res, res_nxt;
   logic [CNT_W-1:0]   cnt;
   logic               carry, err_acc;
   logic               accept, last, dig_err;
   logic [DIGIT_W-1:0] dig;
   logic               dig_co;

   bcd_digit_add u_digit (
      .da (op_a[DIGIT_W-1:0]),
      .db (op_b[DIGIT_W-1:0]),
      .ci (carry),
      .d  (dig),
      .co (dig_co)
   );

   assign last    = (cnt == CNT_W'(NDIG - 1));
   assign dig_err = (op_a[DIGIT_W-1:0] > DIGIT_W'(BCD_MAX)) |
                    (op_b[DIGIT_W-1:0] > DIGIT_W'(BCD_MAX));

   // Result digits enter from the top so digit 0 lands at [3:0] after NDIG shifts.
   generate
      if (NDIG == 1) begin : g_one
         assign res_nxt = dig;
      end else begin : g_multi
         assign res_nxt = {dig, res[W-1:DIGIT_W]};
      end
   endgenerate

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         ST_IDLE: begin
            accept = start;
            if (start) state_nxt = ST_ADD;
         end
         ST_ADD: begin
            if (last) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            accept    = start;
            state_nxt = start ? ST_ADD : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         op_a    <= '0;
         op_b    <= '0;
         res     <= '0;
         cnt     <= '0;
         carry   <= 1'b0;
         err_acc <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
         err     <= 1'b0;
      end else begin
         busy <= (state == ST_ADD);
         done <= (state == ST_DONE);
         if (accept) begin
            op_a    <= a;
            op_b    <= b;
            carry   <= cin;
            cnt     <= '0;
            err_acc <= 1'b0;
         end else if (state == ST_ADD) begin
            op_a    <= op_a >> DIGIT_W;
            op_b    <= op_b >> DIGIT_W;
            res     <= res_nxt;
            carry   <= dig_co;
            err_acc <= err_acc | dig_err;
            cnt     <= cnt + 1'b1;
            // Publish using this cycle's digit, carry and error so the last digit counts.
            if (last) begin
               sum  <= res_nxt;
               cout <= dig_co;
               err  <= err_acc | dig_err;
            end
         end
      end
   end

endmodule
